// File: rtl/tri_bbox_scan.sv
// Triangle bounding-box scanner: walks the screen-clipped bbox in raster order,
// asks an external tester about each point and streams out the covered pixels.
module tri_bbox_scan #(
  parameter int SYS_BIT_WIDTH = 32,
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 180
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     tri_valid_in,
  output logic                     tri_ready_out,
  input  logic [SYS_BIT_WIDTH-1:0] tri_ax_in,
  input  logic [SYS_BIT_WIDTH-1:0] tri_ay_in,
  input  logic [SYS_BIT_WIDTH-1:0] tri_bx_in,
  input  logic [SYS_BIT_WIDTH-1:0] tri_by_in,
  input  logic [SYS_BIT_WIDTH-1:0] tri_cx_in,
  input  logic [SYS_BIT_WIDTH-1:0] tri_cy_in,
  output logic                     test_valid_out,
  output logic [SYS_BIT_WIDTH-1:0] test_ax_out,
  output logic [SYS_BIT_WIDTH-1:0] test_ay_out,
  output logic [SYS_BIT_WIDTH-1:0] test_bx_out,
  output logic [SYS_BIT_WIDTH-1:0] test_by_out,
  output logic [SYS_BIT_WIDTH-1:0] test_cx_out,
  output logic [SYS_BIT_WIDTH-1:0] test_cy_out,
  output logic [SYS_BIT_WIDTH-1:0] test_px_out,
  output logic [SYS_BIT_WIDTH-1:0] test_py_out,
  input  logic                     test_done_in,
  input  logic                     test_inside_in,
  output logic                     pix_valid_out,
  input  logic                     pix_ready_in,
  output logic [SYS_BIT_WIDTH-1:0] pix_x_out,
  output logic [SYS_BIT_WIDTH-1:0] pix_y_out,
  output logic                     done_out,
  output logic [SYS_BIT_WIDTH-1:0] pix_count_out
);

  localparam int W = SYS_BIT_WIDTH;
  localparam logic [W-1:0] X_LAST = W'(SCREEN_W - 1);
  localparam logic [W-1:0] Y_LAST = W'(SCREEN_H - 1);
  localparam logic [W-1:0] ONE    = W'(1);

  typedef enum logic [2:0] {S_IDLE, S_BBOX, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  logic [W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0] px_q, py_q, cnt_q;
  logic         bbox_ph_q;
  logic         off_screen, last_pt, advance;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [W-1:0] clip(input logic [W-1:0] v, input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign off_screen = (xmin_q > X_LAST) || (ymin_q > Y_LAST);
  assign last_pt    = (px_q == xmax_q) && (py_q == ymax_q);
  assign advance    = ((state_q == S_WAIT) && test_done_in && !test_inside_in) ||
                      ((state_q == S_EMIT) && pix_ready_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // BBOX takes two cycles: register min/max first, then test the registered
  // bounds so the off-screen compare never sits behind the 3-way min/max.
  always_comb begin
    state_d        = state_q;
    tri_ready_out  = 1'b0;
    test_valid_out = 1'b0;
    pix_valid_out  = 1'b0;
    done_out       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tri_ready_out = rst_n_in;
        if (tri_valid_in) state_d = S_BBOX;
      end
      S_BBOX:  if (bbox_ph_q) state_d = off_screen ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        test_valid_out = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (test_done_in) begin
          if (test_inside_in) state_d = S_EMIT;
          else                state_d = last_pt ? S_DONE : S_ISSUE;
        end
      end
      S_EMIT: begin
        pix_valid_out = 1'b1;
        if (pix_ready_in) state_d = last_pt ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
      xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      px_q <= '0; py_q <= '0; cnt_q <= '0;
      bbox_ph_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && tri_valid_in) begin
        ax_q  <= tri_ax_in; ay_q <= tri_ay_in;
        bx_q  <= tri_bx_in; by_q <= tri_by_in;
        cx_q  <= tri_cx_in; cy_q <= tri_cy_in;
        cnt_q <= '0;
      end
      if (state_q == S_BBOX) begin
        bbox_ph_q <= ~bbox_ph_q;
        if (!bbox_ph_q) begin
          xmin_q <= min3(ax_q, bx_q, cx_q);
          xmax_q <= clip(max3(ax_q, bx_q, cx_q), X_LAST);
          ymin_q <= min3(ay_q, by_q, cy_q);
          ymax_q <= clip(max3(ay_q, by_q, cy_q), Y_LAST);
        end else if (!off_screen) begin
          px_q <= xmin_q;
          py_q <= ymin_q;
        end
      end
      // The last point holds its coordinates so counters never step past the bbox.
      if (advance && !last_pt) begin
        if (px_q == xmax_q) begin
          px_q <= xmin_q;
          py_q <= py_q + ONE;
        end else begin
          px_q <= px_q + ONE;
        end
      end
      if ((state_q == S_EMIT) && pix_ready_in) cnt_q <= cnt_q + ONE;
    end
  end

  assign test_ax_out   = ax_q;
  assign test_ay_out   = ay_q;
  assign test_bx_out   = bx_q;
  assign test_by_out   = by_q;
  assign test_cx_out   = cx_q;
  assign test_cy_out   = cy_q;
  assign test_px_out   = px_q;
  assign test_py_out   = py_q;
  assign pix_x_out     = px_q;
  assign pix_y_out     = py_q;
  assign pix_count_out = cnt_q;

endmodule

// File: doc/tri_bbox_scan.md
TRI_BBOX_SCAN -- requirements
Module: tri_bbox_scan

Interface
REQ-001 Parameter: SYS_BIT_WIDTH, 32, width of every coordinate.
REQ-002 Parameter: SCREEN_W, 320, screen width in pixels; x is legal in 0..SCREEN_W-1.
REQ-003 Parameter: SCREEN_H, 180, screen height in pixels; y is legal in 0..SCREEN_H-1.
REQ-004 Ports:
- clk_in  in  1  the only clock; all logic is on its rising edge.
- rst_n_in  in  1  asynchronous reset, active-low.
- tri_valid_in  in  1  triangle offered.
- tri_ready_out  out  1  scanner is idle and can accept a triangle.
- tri_ax_in, tri_ay_in, tri_bx_in, tri_by_in, tri_cx_in, tri_cy_in  in  SYS_BIT_WIDTH each  unsigned vertex coordinates.
- test_valid_out  out  1  one-cycle request to the downstream point-in-triangle tester.
- test_ax_out ... test_cy_out  out  SYS_BIT_WIDTH each  latched vertices; stable for the whole scan.
- test_px_out, test_py_out  out  SYS_BIT_WIDTH each  point under test.
- test_done_in  in  1  tester result valid (one-cycle pulse).
- test_inside_in  in  1  tester verdict; qualified by test_done_in.
- pix_valid_out  out  1  covered pixel available.
- pix_ready_in  in  1  consumer accepts the pixel.
- pix_x_out, pix_y_out  out  SYS_BIT_WIDTH each  covered pixel coordinates.
- done_out  out  1  one-cycle pulse when the triangle scan completes.
- pix_count_out  out  SYS_BIT_WIDTH  pixels emitted for the current or last triangle.

Function
REQ-005 FSM states are IDLE, BBOX, ISSUE, WAIT, EMIT and DONE; the FSM is one-hot or encoded (implementer's choice).
REQ-006 IDLE asserts tri_ready_out=1; every other state asserts tri_ready_out=0; tri_valid_in is ignored outside IDLE.
REQ-007 On tri_valid_in && tri_ready_out in cycle T, the block latches the vertices, clears pix_count_out and enters BBOX in T+1.
REQ-008 BBOX registers the following values, then goes to ISSUE:
- xmin = min(ax,bx,cx), xmax = max(ax,bx,cx), ymin and ymax likewise.
- xmax is clipped to SCREEN_W-1 and ymax is clipped to SCREEN_H-1.
REQ-009 If xmin > SCREEN_W-1 or ymin > SCREEN_H-1 after BBOX, the block goes directly to DONE and emits no pixels and no test requests.
REQ-010 ISSUE asserts test_valid_out for exactly one cycle with the current (px,py), then goes to WAIT; the scan starts at (xmin,ymin).
REQ-011 WAIT holds until test_done_in=1, so latency independence is required; there is at most one outstanding request.
REQ-012 test_done_in is ignored in every state other than WAIT.
REQ-013 On test_done_in in WAIT:
- If test_inside_in=1, the block goes to EMIT.
- Otherwise it advances the point.
REQ-014 EMIT asserts pix_valid_out with pix_x/y = (px,py) and holds the values stable until pix_ready_in=1.
REQ-015 On the pix_ready_in handshake, pix_count_out increments by 1 and the point advances.
REQ-016 Advance is raster order, applied as follows:
- px+1 until xmax is passed, then px=xmin and py+1.
- After (xmax,ymax), go to DONE; otherwise go to ISSUE.
REQ-017 DONE pulses done_out for one cycle, then goes to IDLE; pix_count_out holds until the next triangle is accepted.
REQ-018 A degenerate triangle (all vertices equal) scans a single point; collinear vertices scan the full bbox.
REQ-019 All comparisons are unsigned, SYS_BIT_WIDTH wide; coordinate counters never exceed xmax/ymax, so they never wrap.

Reset
REQ-020 While rst_n_in=0, the state is IDLE and the outputs are as follows:
- tri_ready_out=0.
- test_valid_out, pix_valid_out and done_out are 0.
- pix_count_out and all coordinate outputs are 0.
REQ-021 tri_ready_out=1 in the first cycle after rst_n_in deasserts.
REQ-022 Reset mid-scan aborts immediately, with no done_out and no pending pixel; a subsequent triangle scans normally.

Verification
REQ-023 A(2,2) B(5,2) C(2,5), tester model with 3-cycle latency, pix_ready_in=1 -> 16 requests, 10 pixels emitted in raster order, done_out once, pix_count_out=10.
REQ-024 A=B=C=(7,9) -> 1 request at (7,9), and done_out after the verdict; pix_count_out is 1 if inside, else 0.
REQ-025 A(318,178) B(400,178) C(318,300) -> bbox clipped to x 318..319, y 178..179, 4 requests; no coordinate outside the screen.
REQ-026 A(500,10) B(600,10) C(550,20) -> no test_valid_out, done_out 3 cycles after acceptance, pix_count_out=0.
REQ-027 Scenario of REQ-023 with pix_ready_in low for 5 cycles on every pixel -> pix_x/y stable while stalled, same 10 pixels, and tri_valid_in during the scan is not accepted.
REQ-028 Reset asserted during the 3rd WAIT -> all outputs 0 asynchronously; a new triangle reproduces the REQ-023 result exactly.
